fpadd_issue_ctrl: RTL and testbench
===================================

Name: fpadd_issue_ctrl

Overview:
- Upstream operand-issue stage for the single-cycle FP32 adder (fpadd_single).
- Accepts operand pairs on a valid/ready stream and screens each pair for zero, subnormal, Inf and NaN. Normal/normal pairs go to the adder; all other pairs are resolved locally as bypass results.
- Recombines adder results and bypass results in strict issue order into an output FIFO with valid/ready backpressure, so the adder only ever sees normal operands.

Parameters:
- ADD_LATENCY, 2, clock edges from an add_a/add_b update until the matching add_out is stable (fpadd_single = 2).
- FIFO_DEPTH, 8, output FIFO entries; also the credit limit. Must be ≥ ADD_LATENCY+2 for full throughput.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset. Integration drives the adder's active-high reset with ~reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept a pair.
- in_a  in  32  FP32 operand A.
- in_b  in  32  FP32 operand B.
- add_a  out  32  registered operand to adder reg_A.
- add_b  out  32  registered operand to adder reg_B.
- add_out  in  32  adder result.
- res_valid  out  1  result available (FIFO non-empty).
- res_ready  in  1  consumer takes result.
- res_data  out  32  FP32 result (FIFO head).
- res_flags  out  3  {bypass, nan, inf} for FIFO head.

Behaviour:
- Reset (reset=0, async):
  - add_a, add_b, res_data, res_flags = 0; res_valid = 0.
  - FIFO pointers/count and delay line cleared; in_ready = 0 while reset is asserted.
  - Reset mid-operation discards every in-flight and queued result; nothing stale appears after release.
- Accept: on an edge with in_valid && in_ready. in_ready = (fifo_count + inflight) < FIFO_DEPTH (credit scheme). The FIFO therefore never overflows and add_out is never dropped.
- Classification per operand:
  - zero/subnormal: exp==0 (subnormal flushed to zero, sign kept).
  - inf: exp==255, mant==0.
  - nan: exp==255, mant!=0.
  - normal: otherwise.
- Bypass result priority:
  1. Any NaN, or inf+inf with opposite signs → 0x7FC00000, nan=1.
  2. Any inf → that inf, inf=1.
  3. Both zero → sign = signA & signB, rest 0.
  4. One zero → the other operand unchanged.
  - bypass=1 for all four cases.
- Normal/normal: add_a/add_b <= in_a/in_b on the accept edge, flags=000. add_a/add_b hold their value when not issuing.
- Delay line: ADD_LATENCY+1 stages of {valid, bypass, bypass_data, flags}; the slot enters on the accept edge (E). At edge E+ADD_LATENCY+1 the slot exits and pushes (bypass ? bypass_data : add_out) into the FIFO. Bubbles shift through as valid=0.
- Latency: res_valid rises after edge E+ADD_LATENCY+1 (3 edges by default) when the FIFO is empty. Bypass results take the same latency, which preserves ordering.
- Throughput: one pair per clock while res_ready=1.
- FIFO: first-word fall-through. Push and pop may occur on the same edge; count is unchanged and both are honoured. Pointers wrap modulo FIFO_DEPTH.
- Out of scope: overflow/underflow of the adder result (same contract as the adder). No rounding.

Decomposition:
- Shared package fp32_pkg:
  - field widths and slices (SIGN, EXP[7:0], MANT[22:0]);
  - constants EXP_MAX=255, QNAN=0x7FC00000, POS_INF=0x7F800000;
  - class enum {ZERO, NORMAL, INF, NAN};
  - flag bit indices.
- One sub-module: fp_result_fifo (parameterised width 35, depth FIFO_DEPTH, FWFT, count output). Classification stays inline.

Test Plan:
- 1.0+2.0 (0x3F800000, 0x40000000) with adder attached → res_data=0x40400000, flags=000, res_valid exactly 3 edges after accept.
- 0x7FC00001+0x3F800000 → 0x7FC00000, flags=110. 0x7F800000+0xFF800000 → 0x7FC00000, flags=110. 0x7F800000+0x3F800000 → 0x7F800000, flags=101.
- Back-to-back 0x3F800000+0x3F800000, 0x00000000+0x40A00000, 0x40400000+0xBF800000 → outputs 0x40000000, 0x40A00000, 0x40000000 in order on consecutive cycles.
- res_ready=0 with in_valid held high → exactly 8 pairs accepted, then in_ready=0. Raise res_ready → 8 results drain in order with no loss or duplication.
- 0x00000001+0xC0000000 → 0xC0000000, bypass=1. 0x80000000+0x80000000 → 0x80000000. 0x80000000+0x00000000 → 0x00000000.
- Assert reset with 3 pairs in flight and 2 queued → res_valid=0 immediately. After release, no result appears until a new accept, and the first output is that pair's result.

Source files
------------

// File: rtl/fp32_pkg.sv
// FP32 field layout, special constants and operand classes
// shared by the adder issue stage and its result queue.
package fp32_pkg;

    localparam int SIGN    = 31;
    localparam int EXP_HI  = 30;
    localparam int EXP_LO  = 23;
    localparam int MANT_HI = 22;

    localparam logic [7:0]  EXP_MAX = 8'd255;
    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;

    localparam int FLAG_INF = 0;
    localparam int FLAG_NAN = 1;
    localparam int FLAG_BYP = 2;
    localparam int FLAG_W   = 3;

    typedef enum logic [1:0] {
        ZERO,
        NORMAL,
        INF,
        NAN
    } fp_class_e;

    typedef struct packed {
        logic              valid;
        logic              bypass;
        logic [FLAG_W-1:0] flags;
        logic [31:0]       data;
    } slot_t;

    function automatic fp_class_e fp_classify(input logic [31:0] x);
        fp_class_e c;
        if (x[EXP_HI:EXP_LO] == 8'd0)
            c = ZERO;
        else if (x[EXP_HI:0] == POS_INF[EXP_HI:0])
            c = INF;
        else if (x[EXP_HI:EXP_LO] == EXP_MAX && x[MANT_HI:0] != '0)
            c = NAN;
        else
            c = NORMAL;
        return c;
    endfunction

endpackage

// File: rtl/fp_result_fifo.sv
// First-word fall-through result queue with occupancy count;
// simultaneous push and pop are both honoured.
module fp_result_fifo #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty    = (count == '0);
    assign do_push  = push && (count != CW'(DEPTH));
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= nxt(wr_ptr);
            end
            if (do_pop)
                rd_ptr <= nxt(rd_ptr);
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/fpadd_issue_ctrl.sv
// Operand screening and in-order result merge around the
// fixed-latency FP32 adder; special operands bypass the adder.
module fpadd_issue_ctrl
    import fp32_pkg::*;
#(
    parameter int ADD_LATENCY = 2,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    input  logic [31:0] add_out,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic [2:0]  res_flags
);

    localparam int NS = ADD_LATENCY + 1;
    localparam int IW = $clog2(NS + 1);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int DW = FLAG_W + 32;

    fp_class_e         ca;
    fp_class_e         cb;
    logic              byp;
    logic [31:0]       byp_data;
    logic [FLAG_W-1:0] byp_flags;
    logic              accept;
    slot_t             line [NS];
    slot_t             slot_in;
    logic [IW-1:0]     inflight;
    logic [CW-1:0]     fifo_count;
    logic              fifo_empty;
    logic              push;
    logic [DW-1:0]     push_data;
    logic [DW-1:0]     head;
    int                used;

    always_comb begin
        ca        = fp_classify(in_a);
        cb        = fp_classify(in_b);
        byp       = !(ca == NORMAL && cb == NORMAL);
        byp_data  = '0;
        byp_flags = '0;
        if (ca == NAN || cb == NAN ||
            (ca == INF && cb == INF && in_a[SIGN] != in_b[SIGN])) begin
            byp_data            = QNAN;
            byp_flags[FLAG_NAN] = 1'b1;
        end else if (ca == INF) begin
            byp_data            = in_a;
            byp_flags[FLAG_INF] = 1'b1;
        end else if (cb == INF) begin
            byp_data            = in_b;
            byp_flags[FLAG_INF] = 1'b1;
        end else if (ca == ZERO && cb == ZERO) begin
            // subnormals flush to zero; only a -0 + -0 keeps the sign
            byp_data = {in_a[SIGN] & in_b[SIGN], 31'd0};
        end else if (ca == ZERO) begin
            byp_data = in_b;
        end else begin
            byp_data = in_a;
        end
        byp_flags[FLAG_BYP] = byp;
    end

    always_comb begin
        inflight = '0;
        for (int i = 0; i < NS; i++)
            inflight = inflight + IW'(line[i].valid);
    end

    // credits cover both queued and in-flight slots so add_out is never dropped
    assign used     = int'(fifo_count) + int'(inflight);
    assign in_ready = reset && (used < FIFO_DEPTH);
    assign accept   = in_valid && in_ready;

    always_comb begin
        slot_in.valid  = 1'b1;
        slot_in.bypass = byp;
        slot_in.flags  = byp_flags;
        slot_in.data   = byp_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            add_a <= '0;
            add_b <= '0;
            for (int i = 0; i < NS; i++)
                line[i] <= '0;
        end else begin
            if (accept && !byp) begin
                add_a <= in_a;
                add_b <= in_b;
            end
            line[0] <= accept ? slot_in : '0;
            for (int i = 1; i < NS; i++)
                line[i] <= line[i-1];
        end
    end

    assign push      = line[NS-1].valid;
    assign push_data = {line[NS-1].flags,
                        line[NS-1].bypass ? line[NS-1].data : add_out};

    fp_result_fifo #(
        .WIDTH (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (res_ready),
        .pop_data  (head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign res_valid              = !fifo_empty;
    assign {res_flags, res_data}  = fifo_empty ? '0 : head;

endmodule

// File: tb/tb_fpadd_issue_ctrl.sv
// Scoreboard bench for fpadd_issue_ctrl with a two-cycle stand-in
// adder covering the normal operand pairs used here.
module tb_fpadd_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic [31:0] add_out = '0;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic [2:0]  res_flags;

    logic [34:0] sb [$];
    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] PA [8] = '{
        32'h3F800000, 32'h3F800000, 32'h40400000, 32'h40000000,
        32'h3F800000, 32'h40400000, 32'h40000000, 32'h40800000};
    localparam logic [31:0] PB [8] = '{
        32'h40000000, 32'h3F800000, 32'hBF800000, 32'h40000000,
        32'h40400000, 32'h40400000, 32'h40400000, 32'h3F800000};
    localparam logic [31:0] PS [8] = '{
        32'h40400000, 32'h40000000, 32'h40000000, 32'h40800000,
        32'h40800000, 32'h40C00000, 32'h40A00000, 32'h40A00000};

    always #5 clk = ~clk;

    fpadd_issue_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_out   (add_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_flags (res_flags)
    );

    function automatic logic [31:0] stub_sum(input logic [31:0] a,
                                             input logic [31:0] b);
        logic [31:0] r = 32'hDEADBEEF;
        for (int i = 0; i < 8; i++)
            if (PA[i] == a && PB[i] == b)
                r = PS[i];
        return r;
    endfunction

    logic [31:0] st_a = '0;
    logic [31:0] st_b = '0;
    always @(posedge clk) begin
        st_a    <= add_a;
        st_b    <= add_b;
        add_out <= stub_sum(st_a, st_b);
    end

    task automatic chk(input string name, input logic [34:0] act,
                       input logic [34:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset && res_valid && res_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: got %h expected none",
                         {res_flags, res_data});
            end else begin
                chk("result", {res_flags, res_data}, sb.pop_front());
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic [34:0] exp);
        int n = 0;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1");
        end else begin
            sb.push_back(exp);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d left expected 0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc;
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        res_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_res_valid", {34'd0, res_valid}, 35'd0);
        chk("rst_res_data", {3'd0, res_data}, 35'd0);
        chk("rst_res_flags", {32'd0, res_flags}, 35'd0);
        chk("rst_add_a", {3'd0, add_a}, 35'd0);
        chk("rst_add_b", {3'd0, add_b}, 35'd0);
        chk("rst_in_ready", {34'd0, in_ready}, 35'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // 1.0 + 2.0 through the adder, latency measured from accept
        send(32'h3F800000, 32'h40000000, {3'b000, 32'h40400000});
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("latency_%0d", k), {34'd0, res_valid},
                {34'd0, k == 3});
        end
        drain();

        send(32'h7FC00001, 32'h3F800000, {3'b110, 32'h7FC00000});
        send(32'h7F800000, 32'hFF800000, {3'b110, 32'h7FC00000});
        send(32'h7F800000, 32'h3F800000, {3'b101, 32'h7F800000});
        drain();

        // mixed adder/bypass burst must come back in order, back to back
        send(32'h3F800000, 32'h3F800000, {3'b000, 32'h40000000});
        send(32'h00000000, 32'h40A00000, {3'b100, 32'h40A00000});
        send(32'h40400000, 32'hBF800000, {3'b000, 32'h40000000});
        @(negedge clk);
        chk("burst_gap", {34'd0, res_valid}, 35'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("burst_valid_%0d", k), {34'd0, res_valid}, 35'd1);
        end
        drain();

        send(32'h00000001, 32'hC0000000, {3'b100, 32'hC0000000});
        send(32'h80000000, 32'h80000000, {3'b100, 32'h80000000});
        send(32'h80000000, 32'h00000000, {3'b100, 32'h00000000});
        drain();

        // credit limit under backpressure
        res_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 20; c++) begin
            in_a     = PA[acc % 8];
            in_b     = PB[acc % 8];
            in_valid = 1'b1;
            if (in_ready) begin
                sb.push_back({3'b000, PS[acc % 8]});
                acc++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("credit_accepts", 35'(acc), 35'd8);
        chk("credit_in_ready", {34'd0, in_ready}, 35'd0);
        res_ready = 1'b1;
        drain();

        // reset with three in flight and two queued
        res_ready = 1'b0;
        send(32'h3F800000, 32'h40000000, {3'b000, 32'h40400000});
        send(32'h7F800000, 32'h3F800000, {3'b101, 32'h7F800000});
        send(32'h3F800000, 32'h3F800000, {3'b000, 32'h40000000});
        send(32'h00000000, 32'h40A00000, {3'b100, 32'h40A00000});
        send(32'h40000000, 32'h40400000, {3'b000, 32'h40A00000});
        chk("pre_reset_valid", {34'd0, res_valid}, 35'd1);
        reset = 1'b0;
        #1;
        chk("reset_res_valid", {34'd0, res_valid}, 35'd0);
        chk("reset_in_ready", {34'd0, in_ready}, 35'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset     = 1'b1;
        res_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("post_reset_idle_%0d", k), {34'd0, res_valid},
                35'd0);
        end
        @(posedge clk);
        #1;
        send(32'h40800000, 32'h3F800000, {3'b000, 32'h40A00000});
        drain();

        repeat (4) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
